// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the sequential nibble multiplier controller.
package mul_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  // Number of nibble-pair steps needed for a width x width product.
  function automatic int nstep(input int width);
    return (width / NIB_W) * (width / NIB_W);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand/result handshake bundle between source, controller and sink.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, busy
  );
endinterface

// File: rtl/mul_seq_ctrl_mul4u.sv
// 4x4 unsigned exact combinational multiplier, shared by every controller step.
module mul4u (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  assign p_o = {4'b0000, a_i} * {4'b0000, b_i};
endmodule

// File: rtl/mul_seq_ctrl.sv
// WIDTH x WIDTH unsigned multiplier built by time-sharing one 4x4 core over (WIDTH/4)^2 steps.
// Optional ZERO_SKIP_EN: a zero operand bypasses CALC and reports prod=0 one edge after accept.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  mul_seq_ctrl_if.slave bus
);

  localparam int NDIG  = WIDTH / NIB_W;
  localparam int NSTEP = nstep(WIDTH);
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]    step_q, step_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [CW-1:0]    i_idx, j_idx;
  logic [3:0]       nib_a, nib_b;
  logic [7:0]       pp;
  logic [PW-1:0]    pp_sh, acc_sum;

  // Nibble indices come straight from the step counter, i-major.
  assign i_idx = step_q / CW'(NDIG);
  assign j_idx = step_q % CW'(NDIG);
  assign nib_a = a_q[NIB_W*i_idx +: NIB_W];
  assign nib_b = b_q[NIB_W*j_idx +: NIB_W];

  mul4u u_core (
    .a_i (nib_a),
    .b_i (nib_b),
    .p_o (pp)
  );

  assign pp_sh   = PW'(pp) << (NIB_W * (i_idx + j_idx));
  assign acc_sum = acc_q + pp_sh;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          acc_d      = '0;
          step_d     = '0;
          in_ready_d = 1'b0;
`ifdef ZERO_SKIP_EN
          if (bus.a == '0 || bus.b == '0) begin
            prod_d  = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        acc_d = acc_sum;
        if (step_q == CW'(NSTEP - 1)) begin
          prod_d      = acc_sum;
          out_valid_d = 1'b1;
          step_d      = '0;
          state_d     = ST_DONE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      ST_DONE: begin
        // A zero-skip entry arrives with out_valid low; it rises on the next edge.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
